// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and write/read FSM state encodings shared by the slave
package axi_lite_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: NUM_REGS x DATA_WIDTH storage; ports: clk/rst, byte-strobed write port (we/waddr/wdata/wstrb), registered read port (re/raddr/rdata, 0 when out of range)
module axi_lite_regfile #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int NUM_REGS   = 96
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);
   logic [DATA_WIDTH-1:0] mem [NUM_REGS];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (we)
            for (int b = 0; b < DATA_WIDTH/8; b++)
               if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         if (re) rdata <= 32'(raddr) < NUM_REGS ? mem[raddr] : '0;
      end
   end
endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite slave register bank; ports: ACLK/ARESET_N, AW/W/B write channels, AR/R read channels
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int NUM_REGS   = 96
)(
   input  logic                    ACLK,
   input  logic                    ARESET_N,
   input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
   input  logic                    S_AWVALID,
   output logic                    S_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
   input  logic                    S_WVALID,
   output logic                    S_WREADY,
   output logic [1:0]              S_BRESP,
   output logic                    S_BVALID,
   input  logic                    S_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
   input  logic                    S_ARVALID,
   output logic                    S_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_RDATA,
   output logic [1:0]              S_RRESP,
   output logic                    S_RVALID,
   input  logic                    S_RREADY
);
   logic                    rst, aw_hs, w_hs, ar_hs, commit, wr_ok;
   logic [ADDR_WIDTH-1:0]   awaddr_q, wr_addr;
   logic [DATA_WIDTH-1:0]   wdata_q, wr_data;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wr_strb;
   w_state_t                w_state, w_next;
   r_state_t                r_state, r_next;
   always_comb begin
      rst     = !ARESET_N;
      aw_hs   = S_AWVALID && S_AWREADY;
      w_hs    = S_WVALID && S_WREADY;
      ar_hs   = S_ARVALID && S_ARREADY;
      // commit when the last missing half arrives; a live handshake bypasses the latch
      commit  = (aw_hs || w_state == W_HAVE_ADDR) && (w_hs || w_state == W_HAVE_DATA);
      wr_addr = aw_hs ? S_AWADDR : awaddr_q;
      wr_data = w_hs ? S_WDATA : wdata_q;
      wr_strb = w_hs ? S_WSTRB : wstrb_q;
      wr_ok   = 32'(wr_addr) < NUM_REGS;
      w_next  = commit ? W_RESP :
                w_state == W_RESP ? (S_BREADY ? W_IDLE : W_RESP) :
                aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : w_state;
      r_next  = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (S_RREADY ? R_IDLE : R_DATA);
   end
   always_ff @(posedge ACLK) begin
      if (rst) begin
         w_state   <= W_IDLE;
         S_AWREADY <= 1'b0;
         S_WREADY  <= 1'b0;
         S_BVALID  <= 1'b0;
         S_BRESP   <= RESP_OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         w_state   <= w_next;
         S_AWREADY <= w_next == W_IDLE || w_next == W_HAVE_DATA;
         S_WREADY  <= w_next == W_IDLE || w_next == W_HAVE_ADDR;
         S_BVALID  <= w_next == W_RESP;
         if (commit) S_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (aw_hs) awaddr_q <= S_AWADDR;
         if (w_hs) begin
            wdata_q <= S_WDATA;
            wstrb_q <= S_WSTRB;
         end
      end
   end
   always_ff @(posedge ACLK) begin
      if (rst) begin
         r_state   <= R_IDLE;
         S_ARREADY <= 1'b0;
         S_RVALID  <= 1'b0;
         S_RRESP   <= RESP_OKAY;
      end else begin
         r_state   <= r_next;
         S_ARREADY <= r_next == R_IDLE;
         S_RVALID  <= r_next == R_DATA;
         if (ar_hs) S_RRESP <= 32'(S_ARADDR) < NUM_REGS ? RESP_OKAY : RESP_SLVERR;
      end
   end
   axi_lite_regfile #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .NUM_REGS  (NUM_REGS)
   ) u_regfile (
      .clk  (ACLK),
      .rst  (rst),
      .we   (commit && wr_ok),
      .waddr(wr_addr),
      .wdata(wr_data),
      .wstrb(wr_strb),
      .re   (ar_hs),
      .raddr(S_ARADDR),
      .rdata(S_RDATA)
   );
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed self-checking bench for the AXI4-Lite register slave
module tb_axi_lite_slave_regs;
   logic       ACLK = 1'b0, ARESET_N = 1'b0;
   logic [6:0] S_AWADDR = '0, S_ARADDR = '0;
   logic       S_AWVALID = 1'b0, S_WVALID = 1'b0, S_BREADY = 1'b0, S_ARVALID = 1'b0, S_RREADY = 1'b0;
   logic [7:0] S_WDATA = '0;
   logic [0:0] S_WSTRB = 1'b1;
   logic       S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
   logic [1:0] S_BRESP, S_RRESP;
   logic [7:0] S_RDATA;
   int n_chk = 0, n_pass = 0;
   axi_lite_slave_regs dut (
      .ACLK(ACLK), .ARESET_N(ARESET_N),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );
   always #5 ACLK = ~ACLK;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask
   task automatic b_accept();
      S_BREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0;
      check("b_done", S_BVALID, 0);
   endtask
   task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [1:0] resp);
      logic aw_go, w_go;
      @(negedge ACLK);
      S_AWADDR = a; S_AWVALID = 1'b1; S_WDATA = d; S_WVALID = 1'b1;
      for (int i = 0; i < 20 && (S_AWVALID || S_WVALID); i++) begin
         aw_go = S_AWREADY; w_go = S_WREADY;
         @(negedge ACLK);
         if (aw_go) S_AWVALID = 1'b0;
         if (w_go) S_WVALID = 1'b0;
      end
      check("wr_hs", S_AWVALID | S_WVALID, 0);
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      check("bvalid", S_BVALID, 1);
      check("bresp", S_BRESP, resp);
      b_accept();
   endtask
   task automatic do_read(input logic [6:0] a, input logic [7:0] d, input logic [1:0] resp);
      logic go;
      @(negedge ACLK);
      S_ARADDR = a; S_ARVALID = 1'b1;
      for (int i = 0; i < 20 && S_ARVALID; i++) begin
         go = S_ARREADY;
         @(negedge ACLK);
         if (go) S_ARVALID = 1'b0;
      end
      check("ar_hs", S_ARVALID, 0);
      S_ARVALID = 1'b0;
      check("rvalid", S_RVALID, 1);
      check("rdata", S_RDATA, d);
      check("rresp", S_RRESP, resp);
      S_RREADY = 1'b1;
      @(negedge ACLK);
      S_RREADY = 1'b0;
      check("r_done", S_RVALID, 0);
   endtask
   initial begin
      repeat (2) @(negedge ACLK);
      check("rst_awready", S_AWREADY, 0);
      check("rst_wready", S_WREADY, 0);
      check("rst_arready", S_ARREADY, 0);
      check("rst_bvalid", S_BVALID, 0);
      check("rst_rvalid", S_RVALID, 0);
      check("rst_rdata", S_RDATA, 0);
      check("rst_bresp", S_BRESP, 0);
      check("rst_rresp", S_RRESP, 0);
      ARESET_N = 1'b1;
      @(negedge ACLK);
      check("post_awready", S_AWREADY, 1);
      check("post_wready", S_WREADY, 1);
      check("post_arready", S_ARREADY, 1);
      // same-cycle AW+W
      do_write(7'h05, 8'hA5, 2'b00);
      do_read(7'h05, 8'hA5, 2'b00);
      // W three cycles ahead of AW
      @(negedge ACLK);
      S_WDATA = 8'h3C; S_WVALID = 1'b1;
      @(negedge ACLK);
      S_WVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("gap_wready", S_WREADY, 0);
         check("gap_awready", S_AWREADY, 1);
         check("gap_bvalid", S_BVALID, 0);
         if (i < 2) @(negedge ACLK);
      end
      S_AWADDR = 7'h10; S_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      check("late_bvalid", S_BVALID, 1);
      check("late_bresp", S_BRESP, 0);
      b_accept();
      @(negedge ACLK);
      check("single_b", S_BVALID, 0);
      do_read(7'h10, 8'h3C, 2'b00);
      // decode boundary and out-of-range
      do_write(7'h70, 8'hFF, 2'b10);
      do_read(7'h70, 8'h00, 2'b10);
      do_read(7'h6F, 8'h00, 2'b10);
      do_read(7'h5F, 8'h00, 2'b00);
      do_write(7'h5F, 8'h5F, 2'b00);
      do_write(7'h60, 8'h66, 2'b10);
      do_read(7'h5F, 8'h5F, 2'b00);
      do_read(7'h60, 8'h00, 2'b10);
      // BREADY withheld, second AW offered
      @(negedge ACLK);
      S_AWADDR = 7'h30; S_AWVALID = 1'b1; S_WDATA = 8'h77; S_WVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hold_bvalid", S_BVALID, 1);
         check("hold_bresp", S_BRESP, 0);
         check("hold_awready", S_AWREADY, 0);
         check("hold_wready", S_WREADY, 0);
         if (i == 1) begin
            S_AWADDR = 7'h31; S_AWVALID = 1'b1;
         end
         @(negedge ACLK);
      end
      S_BREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0;
      check("hold_b_done", S_BVALID, 0);
      check("hold_awready_back", S_AWREADY, 1);
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      check("pend_awready", S_AWREADY, 0);
      check("pend_wready", S_WREADY, 1);
      S_WDATA = 8'h88; S_WVALID = 1'b1;
      @(negedge ACLK);
      S_WVALID = 1'b0;
      check("pend_bvalid", S_BVALID, 1);
      check("pend_bresp", S_BRESP, 0);
      b_accept();
      do_read(7'h30, 8'h77, 2'b00);
      do_read(7'h31, 8'h88, 2'b00);
      // read-before-write in the same edge
      do_write(7'h20, 8'h11, 2'b00);
      @(negedge ACLK);
      S_AWADDR = 7'h20; S_AWVALID = 1'b1; S_WDATA = 8'h22; S_WVALID = 1'b1;
      S_ARADDR = 7'h20; S_ARVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
      check("rbw_rvalid", S_RVALID, 1);
      check("rbw_rdata", S_RDATA, 8'h11);
      check("rbw_bvalid", S_BVALID, 1);
      S_BREADY = 1'b1; S_RREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0; S_RREADY = 1'b0;
      check("rbw_rdone", S_RVALID, 0);
      check("rbw_bdone", S_BVALID, 0);
      do_read(7'h20, 8'h22, 2'b00);
      // reset between AW and W
      @(negedge ACLK);
      S_AWADDR = 7'h40; S_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      check("mid_wready", S_WREADY, 1);
      ARESET_N = 1'b0;
      @(negedge ACLK);
      check("mid_awready", S_AWREADY, 0);
      check("mid_wready_rst", S_WREADY, 0);
      check("mid_arready", S_ARREADY, 0);
      check("mid_bvalid", S_BVALID, 0);
      check("mid_rvalid", S_RVALID, 0);
      ARESET_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         check("mid_no_b", S_BVALID, 0);
         check("mid_awready_back", S_AWREADY, 1);
         check("mid_wready_back", S_WREADY, 1);
      end
      do_read(7'h40, 8'h00, 2'b00);
      do_read(7'h05, 8'h00, 2'b00);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
